// File: rtl/vram_pkg.sv
// Shared definitions for the video RAM arbiter: widths, region bases and
// the CPU read state machine encoding.
package vram_pkg;

    // 8 KB video RAM, byte wide.
    localparam int VRAM_AW = 13;
    localparam int VRAM_DW = 8;

    // Pixel data occupies 0x0000-0x17FF, character attributes 0x1800-0x1AFF.
    // Everything above 0x1AFF is still ordinary RAM; there is no wrap logic.
    localparam logic [VRAM_AW-1:0] PIX_BASE  = 13'h0000;
    localparam logic [VRAM_AW-1:0] ATTR_BASE = 13'h1800;

    // CPU read sequencing: wait for a free slot, then capture the BRAM data.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DATA = 2'd2
    } rd_state_t;

endpackage

// File: rtl/vram_wbuf.sv
// One-entry posted-write buffer. The CPU write is captured here and drained
// into the BRAM on the first cycle the video port leaves the slot free.
// The address comparator lets a CPU read of the buffered location be served
// straight from the buffer.
module vram_wbuf
    import vram_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [AW-1:0] load_a,
    input  logic [DW-1:0] load_d,
    input  logic          drain,
    input  logic [AW-1:0] cmp_a,
    output logic          valid,
    output logic [AW-1:0] a,
    output logic [DW-1:0] d,
    output logic          hit
);

    // Buffer entry: a load in the same cycle as a drain refills the entry,
    // so the new write takes precedence over clearing valid.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            valid <= 1'b0;
            a     <= '0;
            d     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            a     <= load_a;
            d     <= load_d;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // Forwarding match: only a live entry can satisfy a read.
    assign hit = valid && (a == cmp_a);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter. The video fetch port always owns the BRAM
// slot when it asks; CPU writes are posted through a one-entry buffer and
// CPU reads wait for a cycle nobody else wants. Video data comes back one
// cycle after the request, unconditionally.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) (
    input  logic          clock,
    input  logic          reset,
    // video fetch port
    input  logic          vid_req,
    input  logic [AW-1:0] vid_a,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_valid,
    // CPU data bus
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_wd,
    input  logic          cpu_we,
    input  logic          cpu_rd,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    // BRAM port
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_wd,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q
);

    rd_state_t     state;
    rd_state_t     state_next;

    logic          wb_valid;
    logic [AW-1:0] wb_a;
    logic [DW-1:0] wb_d;
    logic          wb_hit;
    logic          wb_load;
    logic          wb_drain;

    logic [AW-1:0] rd_a;
    logic          rd_a_load;
    logic          rd_issue;
    logic          rd_capture;

    logic          cpu_free;
    logic          rd_start;
    logic          fwd;

    logic [AW-1:0] ram_a_hold;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------

    // The cycle carrying cpu_ready still sees the old request held high, so
    // new requests are only taken once the pulse has passed.
    assign cpu_free = (state == IDLE) && !cpu_ready;

    // The buffer gives its entry to the BRAM whenever video is quiet.
    assign wb_drain = wb_valid && !vid_req;

    // A write enters the buffer if it is empty or emptying this cycle.
    assign wb_load  = cpu_free && cpu_we && (!wb_valid || wb_drain);

    // A simultaneous write wins over a read.
    assign rd_start = cpu_free && cpu_rd && !cpu_we;

    // A read of the buffered address is answered from the buffer directly.
    assign fwd      = rd_start && wb_hit;

    // The read owns the slot only once video and the buffer are both idle,
    // which also guarantees a buffered write lands before any read issues.
    assign rd_issue = (state == RD_WAIT) && !vid_req && !wb_valid;

    vram_wbuf #(
        .AW (AW),
        .DW (DW)
    ) u_wbuf (
        .clock  (clock),
        .reset  (reset),
        .load   (wb_load),
        .load_a (cpu_a),
        .load_d (cpu_wd),
        .drain  (wb_drain),
        .cmp_a  (cpu_a),
        .valid  (wb_valid),
        .a      (wb_a),
        .d      (wb_d),
        .hit    (wb_hit)
    );

    // ------------------------------------------------------------------
    // BRAM slot mux: video, then buffered write, then pending read
    // ------------------------------------------------------------------

    // Priority mux for the single BRAM port; idle cycles keep the last address.
    always_comb begin
        // NOTE: every output gets a default before the priority chain so no
        // path leaves a signal unassigned and no latch is inferred.
        ram_a  = ram_a_hold;
        ram_we = 1'b0;
        ram_wd = wb_d;
        if (reset) begin
            ram_a = '0;
        end else if (vid_req) begin
            ram_a = vid_a;
        end else if (wb_valid) begin
            ram_a  = wb_a;
            ram_we = 1'b1;
        end else if (state == RD_WAIT) begin
            ram_a = rd_a;
        end
    end

    // Remember the address driven last cycle so idle cycles do not toggle it.
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_a_hold <= '0;
        end else begin
            ram_a_hold <= ram_a;
        end
    end

    // ------------------------------------------------------------------
    // CPU read state machine
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the strobes that load the read datapath.
    always_comb begin
        state_next = state;
        rd_a_load  = 1'b0;
        rd_capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd_start && !wb_hit) begin
                    state_next = RD_WAIT;
                    rd_a_load  = 1'b1;
                end
            end
            RD_WAIT: begin
                if (rd_issue) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                rd_capture = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and read datapath
    // ------------------------------------------------------------------

    // CPU completion pulse, read data capture and latched read address.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            rd_a      <= '0;
        end else begin
            cpu_ready <= wb_load || fwd || rd_capture;
            if (fwd) begin
                cpu_rdata <= wb_d;
            end else if (rd_capture) begin
                cpu_rdata <= ram_q;
            end
            if (rd_a_load) begin
                rd_a <= cpu_a;
            end
        end
    end

    // Video data qualifier trails the request by the BRAM read latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            vid_valid <= 1'b0;
        end else begin
            vid_valid <= vid_req;
        end
    end

    // BRAM output goes straight to the scan-out stage.
    assign vid_rdata = ram_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous-read BRAM.
module tb_vram_arbiter;
    import vram_pkg::*;

    logic        clock;
    logic        reset;
    logic        vid_req;
    logic [12:0] vid_a;
    logic [7:0]  vid_rdata;
    logic        vid_valid;
    logic [12:0] cpu_a;
    logic [7:0]  cpu_wd;
    logic        cpu_we;
    logic        cpu_rd;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic [12:0] ram_a;
    logic [7:0]  ram_wd;
    logic        ram_we;
    logic [7:0]  ram_q;

    // bench-side preload port into the BRAM model
    logic        pre_we;
    logic [12:0] pre_a;
    logic [7:0]  pre_d;

    logic [7:0]  mem [0:8191];

    logic [7:0]  vid_exp;
    bit          vga_on;
    int          vga_cnt;
    int          vectors;
    int          miscompares;
    int          illegal_cnt;

    vram_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .vid_req   (vid_req),
        .vid_a     (vid_a),
        .vid_rdata (vid_rdata),
        .vid_valid (vid_valid),
        .cpu_a     (cpu_a),
        .cpu_wd    (cpu_wd),
        .cpu_we    (cpu_we),
        .cpu_rd    (cpu_rd),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .ram_a     (ram_a),
        .ram_wd    (ram_wd),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read BRAM, read-before-write.
    always @(posedge clock) begin
        if (pre_we) begin
            mem[pre_a] <= pre_d;
        end else if (ram_we) begin
            mem[ram_a] <= ram_wd;
        end
        ram_q <= mem[ram_a];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic vga_drive();
        int ph;
        ph      = vga_cnt % 16;
        vid_req = (ph < 2);
        vid_a   = (ph == 0) ? 13'h0040 : 13'h1800;
        vid_exp = (ph == 0) ? 8'h66 : 8'h47;
    endtask

    // One clock: every cycle confirms the video port returned what was
    // fetched on the previous cycle.
    task automatic cyc();
        bit         req_s;
        logic [7:0] exp_s;
        req_s = vid_req && !reset;
        exp_s = vid_exp;
        if (cpu_we && cpu_rd) begin
            illegal_cnt++;
            $display("note: cpu_we and cpu_rd both high at %0t, write takes priority", $time);
        end
        @(posedge clock);
        #1;
        check("vid_valid", 32'(vid_valid), 32'(req_s));
        if (req_s) check("vid_rdata", 32'(vid_rdata), 32'(exp_s));
        if (vga_on) begin
            vga_cnt++;
            vga_drive();
        end
    endtask

    task automatic cpu_read(input string tag, input logic [12:0] a, input logic [7:0] exp,
                            input int lo, input int hi);
        int n;
        bit done;
        cpu_a  = a;
        cpu_rd = 1'b1;
        n      = 0;
        done   = 1'b0;
        while (!done && n < 20) begin
            cyc();
            n++;
            if (cpu_ready) done = 1'b1;
        end
        check({tag, "_ready"}, 32'(done), 1);
        check({tag, "_latency"}, 32'(n >= lo && n <= hi), 1);
        check({tag, "_data"}, 32'(cpu_rdata), 32'(exp));
        cpu_rd = 1'b0;
        cyc();
    endtask

    initial begin
        logic [12:0] pa [8];
        logic [7:0]  pd [8];
        pa = '{13'h1800, 13'h0010, 13'h0123, 13'h1A00, 13'h0040, 13'h1FFF, 13'h0500, 13'h0200};
        pd = '{8'h47,    8'h99,    8'h00,    8'h11,    8'h66,    8'hE1,    8'h0F,    8'h00};

        vectors = 0; miscompares = 0; illegal_cnt = 0;
        vga_on = 1'b0; vga_cnt = 0;
        reset = 1'b1;
        vid_req = 1'b0; vid_a = '0; vid_exp = '0;
        cpu_a = '0; cpu_wd = '0; cpu_we = 1'b0; cpu_rd = 1'b0;
        pre_we = 1'b0; pre_a = '0; pre_d = '0;

        // Reset holds the BRAM port at address 0, no write, even with video asking.
        vid_req = 1'b1; vid_a = 13'h1234;
        settle();
        check("rst_ram_a", 32'(ram_a), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        vid_req = 1'b0;

        for (int i = 0; i < 8; i++) begin
            pre_we = 1'b1; pre_a = pa[i]; pre_d = pd[i];
            cyc();
        end
        pre_we = 1'b0;
        cyc();
        check("rst_cpu_ready", 32'(cpu_ready), 0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 0);
        check("rst_vid_valid", 32'(vid_valid), 0);
        reset = 1'b0;
        cyc();

        // Video latency with the CPU idle.
        vid_req = 1'b1; vid_a = 13'h1800; vid_exp = 8'h47;
        settle();
        check("vid_ram_a", 32'(ram_a), 'h1800);
        check("vid_ram_we", 32'(ram_we), 0);
        cyc();
        vid_req = 1'b0;
        cyc();

        // Posted write with no video traffic.
        cpu_a = 13'h0123; cpu_wd = 8'hA5; cpu_we = 1'b1;
        settle();
        check("wr_pre_we", 32'(ram_we), 0);
        cyc();
        check("wr_ready", 32'(cpu_ready), 1);
        check("wr_ram_we", 32'(ram_we), 1);
        check("wr_ram_a", 32'(ram_a), 'h0123);
        check("wr_ram_wd", 32'(ram_wd), 'hA5);
        cpu_we = 1'b0;
        cyc();
        check("wr_ready_pulse", 32'(cpu_ready), 0);
        check("wr_we_done", 32'(ram_we), 0);
        cpu_read("rd_0123", 13'h0123, 8'hA5, 3, 3);

        // Video holds the slot for two cycles; the buffer drains on the third.
        cpu_a = 13'h0200; cpu_wd = 8'h5E; cpu_we = 1'b1;
        settle();
        cyc();
        check("blk_ready", 32'(cpu_ready), 1);
        cpu_we = 1'b0; vid_req = 1'b1; vid_a = 13'h1800; vid_exp = 8'h47;
        settle();
        check("blk_we1", 32'(ram_we), 0);
        check("blk_a1", 32'(ram_a), 'h1800);
        cyc();
        vid_a = 13'h0040; vid_exp = 8'h66;
        settle();
        check("blk_we2", 32'(ram_we), 0);
        cyc();
        vid_req = 1'b0;
        settle();
        check("blk_we3", 32'(ram_we), 1);
        check("blk_a3", 32'(ram_a), 'h0200);
        check("blk_wd3", 32'(ram_wd), 'h5E);
        cyc();
        check("blk_we4", 32'(ram_we), 0);
        cpu_read("rd_0200", 13'h0200, 8'h5E, 3, 3);
        cpu_read("rd_1800", 13'h1800, 8'h47, 3, 3);

        // Forwarding from the buffer while video blocks the drain.
        cpu_a = 13'h1A00; cpu_wd = 8'h3C; cpu_we = 1'b1;
        settle();
        cyc();
        check("fwd_wr_ready", 32'(cpu_ready), 1);
        cpu_we = 1'b0; vid_req = 1'b1; vid_a = 13'h1800; vid_exp = 8'h47;
        settle();
        check("fwd_we1", 32'(ram_we), 0);
        cyc();
        cpu_rd = 1'b1; cpu_a = 13'h1A00; vid_a = 13'h0040; vid_exp = 8'h66;
        settle();
        check("fwd_we2", 32'(ram_we), 0);
        check("fwd_a2", 32'(ram_a), 'h0040);
        cyc();
        check("fwd_ready", 32'(cpu_ready), 1);
        check("fwd_data", 32'(cpu_rdata), 'h3C);
        check("fwd_state", 32'(dut.state), 32'(IDLE));
        cpu_rd = 1'b0; vid_req = 1'b0;
        settle();
        check("fwd_drain_we", 32'(ram_we), 1);
        check("fwd_drain_a", 32'(ram_a), 'h1A00);
        cyc();
        check("fwd_we_after", 32'(ram_we), 0);
        check("fwd_hold_a", 32'(ram_a), 'h1A00);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("fwd_no_rd_ready", 32'(cpu_ready), 0);
        end
        cpu_read("rd_1a00", 13'h1A00, 8'h3C, 3, 3);

        // Write and read together: the write is taken and no read follows.
        cpu_a = 13'h0300; cpu_wd = 8'h12; cpu_we = 1'b1; cpu_rd = 1'b1;
        settle();
        cyc();
        check("both_ready", 32'(cpu_ready), 1);
        check("both_we", 32'(ram_we), 1);
        check("both_a", 32'(ram_a), 'h0300);
        cpu_we = 1'b0; cpu_rd = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("both_no_rd_ready", 32'(cpu_ready), 0);
        end
        cpu_read("rd_0300", 13'h0300, 8'h12, 3, 3);

        // Address above the attribute region is ordinary RAM.
        cpu_read("rd_1fff", 13'h1FFF, 8'hE1, 3, 3);

        // Reads against the VGA fetch pattern (2 of every 16 cycles).
        vga_on = 1'b1; vga_cnt = 0;
        vga_drive();
        for (int i = 0; i < 150; i++) begin
            cpu_read("vga_rd", 13'h0010, 8'h99, 3, 5);
            for (int g = 0; g < (i % 5); g++) cyc();
        end
        vga_on = 1'b0;
        vid_req = 1'b0;
        cyc();
        cyc();

        // Reset while a read waits and a write is buffered.
        cpu_a = 13'h0500; cpu_wd = 8'h77; cpu_we = 1'b1;
        settle();
        cyc();
        check("mid_wr_ready", 32'(cpu_ready), 1);
        cpu_we = 1'b0; vid_req = 1'b1; vid_a = 13'h1800; vid_exp = 8'h47;
        cyc();
        cpu_rd = 1'b1; cpu_a = 13'h0010; vid_a = 13'h0040; vid_exp = 8'h66;
        cyc();
        check("mid_state", 32'(dut.state), 32'(RD_WAIT));
        check("mid_wb_valid", 32'(dut.wb_valid), 1);
        vid_req = 1'b0; reset = 1'b1;
        settle();
        check("mid_rst_we", 32'(ram_we), 0);
        check("mid_rst_a", 32'(ram_a), 0);
        cyc();
        reset = 1'b0; cpu_rd = 1'b0;
        settle();
        check("post_rst_state", 32'(dut.state), 32'(IDLE));
        check("post_rst_wb_valid", 32'(dut.wb_valid), 0);
        check("post_rst_ready", 32'(cpu_ready), 0);
        check("post_rst_rdata", 32'(cpu_rdata), 0);
        check("post_rst_we", 32'(ram_we), 0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("post_rst_no_ready", 32'(cpu_ready), 0);
            check("post_rst_no_we", 32'(ram_we), 0);
        end
        cpu_read("rd_0500", 13'h0500, 8'h0F, 3, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Single-port 8 KB video RAM arbiter. It sits directly upstream of the VGA text/attribute scan-out stage and supplies that stage's 13-bit-address / 8-bit-data fetch port.
- It shares one synchronous-read BRAM between the video fetch port and the AVR CPU data bus.
- Video fetches are never delayed.
- CPU writes are posted through a one-entry write buffer. CPU reads stall until a free RAM slot is available.

Parameters:
- AW, 13, address width (8 KB: pixel 0x0000–0x17FF, attributes 0x1800–0x1AFF).
- DW, 8, data width.

Ports:
- clock  in  1  system clock, same as the VGA stage.
- reset  in  1  synchronous, active-high.
- vid_req  in  1  video fetch strobe, one cycle per address.
- vid_a  in  AW  video fetch address, valid when vid_req=1.
- vid_rdata  out  DW  video read data; equals ram_q.
- vid_valid  out  1  vid_rdata is valid this cycle.
- cpu_a  in  AW  CPU address.
- cpu_wd  in  DW  CPU write data.
- cpu_we  in  1  write request, held until cpu_ready.
- cpu_rd  in  1  read request, held until cpu_ready.
- cpu_rdata  out  DW  CPU read data, valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- ram_a  out  AW  BRAM address.
- ram_wd  out  DW  BRAM write data.
- ram_we  out  1  BRAM write enable.
- ram_q  in  DW  BRAM read data, one cycle after ram_a.

Behaviour:
- Reset values: all registered state clears.
  - state=IDLE, wb_valid=0, cpu_ready=0, cpu_rdata=0, vid_valid=0.
  - ram_we=0 and ram_a=0 while reset is high.
- Reset mid-operation: any pending read is abandoned without a ready pulse, and any buffered write is discarded.
- Slot priority, evaluated combinationally each cycle:
  1. vid_req: ram_a=vid_a, ram_we=0.
  2. Otherwise, wb_valid: ram_a=wb_a, ram_wd=wb_d, ram_we=1; the buffer drains and wb_valid clears next cycle.
  3. Otherwise, state=RD_WAIT: ram_a=rd_a, ram_we=0.
  4. Otherwise, idle: ram_a holds its last value, ram_we=0.
- Video timing:
  - vid_valid is vid_req registered; vid_rdata=ram_q.
  - Fixed latency is 1 cycle and holds regardless of CPU activity.
  - Back-to-back vid_req is legal, e.g. pixel then attribute fetch.
- CPU write:
  - Accepted on a cycle where cpu_we=1, the FSM is IDLE, and (wb_valid=0 or the buffer drains this cycle).
  - On acceptance: wb_a/wb_d are loaded, wb_valid=1, and cpu_ready pulses on the next cycle.
  - If the buffer is full and blocked by video, acceptance waits; cpu_we must stay high.
- CPU read FSM, states IDLE → RD_WAIT → RD_DATA → IDLE:
  - IDLE, cpu_rd=1, wb_valid=1, wb_a==cpu_a: forward. cpu_rdata<=wb_d, cpu_ready pulses next cycle, no RAM access, FSM stays IDLE.
  - IDLE, cpu_rd=1, otherwise: latch rd_a and go to RD_WAIT.
  - RD_WAIT: when the read wins the slot (no vid_req, no wb_valid), go to RD_DATA. Otherwise remain.
  - RD_DATA: cpu_rdata<=ram_q, cpu_ready pulses next cycle, go to IDLE.
  - Minimum read latency from cpu_rd to cpu_ready is 3 cycles.
- Handshake rules:
  - The CPU holds request, address and data stable until cpu_ready=1.
  - A new request may be asserted the cycle after cpu_ready.
  - cpu_we and cpu_rd together is illegal; cpu_we wins. The bench flags it.
- Ordering: a buffered write always drains before a non-forwarded read issues, so read-after-write is coherent.
- Address width: all addresses use AW bits with no wrap logic. Addresses above 0x1AFF are valid RAM.

Decomposition:
- Shared package `vram_pkg`:
  - AW/DW constants.
  - Region bases PIX_BASE=0x0000 and ATTR_BASE=0x1800.
  - FSM state enum {IDLE, RD_WAIT, RD_DATA}.
- Natural sub-module: `vram_wbuf`, the one-entry posted-write buffer (load, drain, address-compare/forward).
- Top level holds the priority mux and the read FSM.

Test Plan:
- Video latency: vid_req with vid_a=0x1800, RAM[0x1800]=0x47 → next cycle vid_valid=1, vid_rdata=0x47, with CPU idle and again with CPU reads pending.
- Posted write: cpu_we, cpu_a=0x0123, cpu_wd=0xA5 with no video → cpu_ready after 1 cycle; ram_we=1 at 0x0123 on the following cycle; a later read returns 0xA5.
- Video blocks drain: write accepted, then vid_req high 2 consecutive cycles → ram_we stays 0 both cycles, drain occurs on the 3rd, and video data is uncorrupted.
- Forwarding: write 0x3C to 0x1A00, then cpu_rd at 0x1A00 while vid_req holds the slot → cpu_ready with cpu_rdata=0x3C and no RAM read issued.
- Read stall: cpu_rd at 0x0010 (RAM=0x99) with vid_req asserted 2 of every 16 cycles (VGA pattern) → cpu_ready within 3–5 cycles, cpu_rdata=0x99, zero video misses over 1000 cycles.
- Reset mid-operation: reset asserted in RD_WAIT with wb_valid=1 → next cycle state=IDLE, wb_valid=0, cpu_ready=0, and no RAM write occurs.
